// File: rtl/mc_ctrlunit_if.sv
// Control-unit bundle: instruction/status inputs from the datapath and the
// one-cycle enables the control unit drives back into it.
interface mc_ctrlunit_if;
    logic [3:0] op;
    logic       zero_in;
    logic       carry_in;
    logic       mem_ready;
    logic       PCWRITE;
    logic       IRWRITE;
    logic       JUMP;
    logic       BRANCH;
    logic [2:0] ALUC;
    logic       ALUSRCB;
    logic       MEMREAD;
    logic       WRITEMEM;
    logic       WRITEREG;
    logic       MEMTOREG;
    logic       REGDES;
    logic       WRFLAG;
    logic       ZF_Q;
    logic       CF_Q;
    logic       ERR;
    logic [2:0] STATE;

    modport master (
        input  op, zero_in, carry_in, mem_ready,
        output PCWRITE, IRWRITE, JUMP, BRANCH, ALUC, ALUSRCB, MEMREAD, WRITEMEM,
               WRITEREG, MEMTOREG, REGDES, WRFLAG, ZF_Q, CF_Q, ERR, STATE
    );

    modport slave (
        output op, zero_in, carry_in, mem_ready,
        input  PCWRITE, IRWRITE, JUMP, BRANCH, ALUC, ALUSRCB, MEMREAD, WRITEMEM,
               WRITEREG, MEMTOREG, REGDES, WRFLAG, ZF_Q, CF_Q, ERR, STATE
    );
endinterface

// File: rtl/mc_ctrlunit.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with memory-wait timeout
// and a Z/C flag register for carry-chained arithmetic.
module mc_ctrlunit #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 8
) (
    input  logic            clk,
    input  logic            rst,
    mc_ctrlunit_if.master   bus
);
    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;

    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_SUBC = 4'h5;
    localparam logic [3:0] OP_ADDC = 4'h6;
    localparam logic [3:0] OP_JMP  = 4'h7;
    localparam logic [3:0] OP_ADDI = 4'hA;
    localparam logic [3:0] OP_LW   = 4'hB;
    localparam logic [3:0] OP_SW   = 4'hC;
    localparam logic [3:0] OP_BEQ  = 4'hD;
    localparam logic [3:0] OP_BNE  = 4'hE;
    localparam logic [3:0] OP_JMPB = 4'hF;

    function automatic logic [2:0] aluc_of(input logic [3:0] o);
        case (o)
            4'h0, 4'h8:                 return 3'b000;
            4'h3, 4'hD, 4'hE:           return 3'b001;
            4'h5:                       return 3'b010;
            4'h4, 4'hF:                 return 3'b011;
            4'h6:                       return 3'b100;
            4'h2, 4'hA, 4'hB, 4'hC:     return 3'b101;
            4'h1, 4'h9:                 return 3'b110;
            default:                    return 3'b000;
        endcase
    endfunction

    logic [2:0]       state, state_nxt;
    logic [3:0]       op_q, opx;
    logic [CNT_W-1:0] cnt;
    logic             zf_q, cf_q, err_q;
    logic             waiting, abort;
    logic             pcw, irw, jmp, br, srcb, mrd, mwr, wreg, mtr, rdes, wrf;
    logic [2:0]       aluc;

    // In DECODE the opcode comes straight from the IR; afterwards from op_q.
    assign opx     = (state == S_DECODE) ? bus.op : op_q;
    assign waiting = ((state == S_FETCH) || (state == S_MEM)) && !bus.mem_ready;
    assign abort   = waiting && (cnt == CNT_W'(TIMEOUT));

    always_comb begin
        state_nxt = state;
        pcw  = 1'b0;  irw  = 1'b0;  jmp  = 1'b0;  br   = 1'b0;
        srcb = 1'b0;  mrd  = 1'b0;  mwr  = 1'b0;  wreg = 1'b0;
        mtr  = 1'b0;  rdes = 1'b0;  wrf  = 1'b0;  aluc = 3'b000;
        case (state)
            S_FETCH: begin
                mrd = 1'b1;
                if (bus.mem_ready) begin
                    irw       = 1'b1;
                    pcw       = 1'b1;
                    state_nxt = S_DECODE;
                end else if (abort) begin
                    state_nxt = S_FETCH;
                end
            end
            S_DECODE: begin
                if (opx == OP_JMP) begin
                    jmp       = 1'b1;
                    state_nxt = S_FETCH;
                end else begin
                    state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                aluc = aluc_of(opx);
                srcb = opx[3] && (opx <= OP_SW);
                wrf  = (opx == OP_ADD) || (opx == OP_SUB) || (opx == OP_SUBC) ||
                       (opx == OP_ADDC) || (opx == OP_ADDI);
                case (opx)
                    OP_BEQ, OP_BNE, OP_JMPB: begin
                        br = ((opx == OP_BEQ) && bus.zero_in) ||
                             ((opx != OP_BEQ) && !bus.zero_in);
                        state_nxt = S_FETCH;
                    end
                    OP_LW, OP_SW: state_nxt = S_MEM;
                    default:      state_nxt = S_WB;
                endcase
            end
            S_MEM: begin
                aluc = aluc_of(opx);
                srcb = 1'b1;
                mrd  = (opx == OP_LW);
                mwr  = (opx == OP_SW);
                if (bus.mem_ready) begin
                    state_nxt = (opx == OP_SW) ? S_FETCH : S_WB;
                end else if (abort) begin
                    state_nxt = S_FETCH;
                end
            end
            S_WB: begin
                wreg      = 1'b1;
                mtr       = (opx == OP_LW);
                rdes      = (opx <= OP_ADDC);
                state_nxt = S_FETCH;
            end
            default: state_nxt = S_FETCH;
        endcase
    end

    // Every combinational enable is suppressed while reset is held.
    assign bus.PCWRITE  = pcw  & ~rst;
    assign bus.IRWRITE  = irw  & ~rst;
    assign bus.JUMP     = jmp  & ~rst;
    assign bus.BRANCH   = br   & ~rst;
    assign bus.ALUC     = rst ? 3'b000 : aluc;
    assign bus.ALUSRCB  = srcb & ~rst;
    assign bus.MEMREAD  = mrd  & ~rst;
    assign bus.WRITEMEM = mwr  & ~rst;
    assign bus.WRITEREG = wreg & ~rst;
    assign bus.MEMTOREG = mtr  & ~rst;
    assign bus.REGDES   = rdes & ~rst;
    assign bus.WRFLAG   = wrf  & ~rst;
    assign bus.ZF_Q     = zf_q;
    assign bus.CF_Q     = cf_q;
    assign bus.ERR      = err_q;
    assign bus.STATE    = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_FETCH;
            op_q  <= 4'h0;
            cnt   <= '0;
            zf_q  <= 1'b0;
            cf_q  <= 1'b0;
            err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == S_DECODE) op_q <= bus.op;
            // Counter only runs while a wait continues in the same state.
            cnt   <= (waiting && !abort) ? cnt + CNT_W'(1) : '0;
            err_q <= abort;
            if (wrf) begin
                zf_q <= bus.zero_in;
                cf_q <= bus.carry_in;
            end
        end
    end
endmodule

// File: doc/mc_ctrlunit.md
# mc_ctrlunit

Multi-cycle control unit for the 16-opcode, 4-bit-op CPU datapath. It sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states and drives one-cycle-qualified datapath enables. It waits on a memory ready handshake with a parametrised timeout, and holds a Z/C flag register used for carry-chained ADDC/SUBC. It replaces the single-cycle decoder and sits between the instruction register, ALU, register file and memory port.

## Interface
- TIMEOUT, 15: maximum wait cycles with mem_ready low in FETCH or MEM before abort; legal range 1..255.
- CNT_W, 8: width of the wait counter; must satisfy 2^CNT_W > TIMEOUT.

- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- op  in  4  opcode from the instruction register; valid from DECODE onward.
- zero_in  in  1  ALU zero result.
- carry_in  in  1  ALU carry/borrow out.
- mem_ready  in  1  memory completed the current access this cycle.
- PCWRITE  out  1  PC <= PC+1.
- IRWRITE  out  1  IR <= memory data.
- JUMP  out  1  PC <= jump target.
- BRANCH  out  1  PC <= branch target.
- ALUC  out  3  ALU function.
- ALUSRCB  out  1  ALU B = immediate.
- MEMREAD  out  1  memory read request.
- WRITEMEM  out  1  memory write request.
- WRITEREG  out  1  register-file write enable.
- MEMTOREG  out  1  write-back source = memory.
- REGDES  out  1  destination = rd field (R-type).
- WRFLAG  out  1  flag register update this cycle.
- ZF_Q, CF_Q  out  1 each  registered flags; CF_Q feeds the ALU carry-in.
- ERR  out  1  one-cycle pulse on memory timeout.
- STATE  out  3  current state, for debug.

## Operation
- Opcodes: AND 0, OR 1, ADD 2, SUB 3, SLT 4, SUBC 5, ADDC 6, JMP 7, ANDI 8, ORI 9, ADDI A, LW B, SW C, BEQ D, BNE E, JMPB F.
- ALUC mapping:
  - AND/ANDI 000
  - SUB/BEQ/BNE 001
  - SUBC 010
  - SLT/JMPB 011
  - ADDC 100
  - ADD/ADDI/LW/SW 101
  - OR/ORI 110
- States and encodings: FETCH 0, DECODE 1, EXEC 2, MEM 3, WB 4. Codes 5-7 are illegal and go to FETCH on the next edge.
- op_q latches op on every DECODE cycle. All outputs except ERR, ZF_Q and CF_Q are combinational from state and op_q (op in DECODE).
- FETCH: MEMREAD=1.
  - mem_ready=1: IRWRITE=1, PCWRITE=1, go to DECODE.
  - mem_ready=0: stay and count.
- DECODE:
  - JMP: JUMP=1, go to FETCH.
  - Otherwise: go to EXEC.
- EXEC: drive ALUC.
  - ALUSRCB=1 for ANDI/ORI/ADDI/LW/SW.
  - Branch ops: BRANCH = (BEQ & zero_in) | (BNE & !zero_in) | (JMPB & !zero_in), go to FETCH.
  - LW/SW: go to MEM.
  - Otherwise: go to WB.
  - WRFLAG=1 for ADD/SUB/SUBC/ADDC/ADDI. On that edge ZF_Q<=zero_in and CF_Q<=carry_in; otherwise flags hold.
- MEM: ALUC/ALUSRCB held as in EXEC.
  - LW: MEMREAD=1. SW: WRITEMEM=1.
  - On mem_ready: SW goes to FETCH, LW goes to WB.
- WB: WRITEREG=1.
  - MEMTOREG=1 for LW.
  - REGDES=1 for AND/OR/ADD/SUB/SLT/SUBC/ADDC.
  - Go to FETCH.
- Timeout:
  - The counter increments each FETCH/MEM cycle with mem_ready=0 and clears on any state change.
  - Abort condition: counter==TIMEOUT with mem_ready=0.
  - On abort, the next state is FETCH, no IRWRITE/PCWRITE/WRITEREG is issued, and ERR=1 the following cycle only.
  - If mem_ready=1 in the same cycle the counter reaches TIMEOUT, ready wins and no ERR is raised.
- Outputs not listed for a state are 0.

## Timing
- Reset:
  - Registers: STATE=FETCH, op_q=0, ZF_Q=0, CF_Q=0, counter=0, ERR=0.
  - While rst=1, all control outputs are forced to 0, including MEMREAD.
  - Reset mid-instruction abandons it with no further writes.
- Latency with zero-wait memory:
  - JMP: 2 cycles.
  - Branches: 3 cycles.
  - SW: 4 cycles.
  - R/I-type: 4 cycles.
  - LW: 5 cycles.
- Each memory wait cycle adds one cycle.
- Every enable is asserted for exactly one cycle per instruction, except MEMREAD/WRITEMEM, which hold through wait cycles.

## Test plan
- Reset then ADD (op=2), mem_ready=1 always -> states 0,1,2,4,0.
  - EXEC: ALUC=101, WRFLAG=1.
  - WB: WRITEREG=1, REGDES=1.
  - zero_in=1 in EXEC -> ZF_Q=1 next cycle.
- LW with mem_ready low for 3 MEM cycles -> MEM lasts 4 cycles with MEMREAD=1 throughout; then WB with MEMTOREG=1, WRITEREG=1, REGDES=0.
- BEQ zero_in=1 -> BRANCH=1 in EXEC. BNE zero_in=1 -> BRANCH=0. JMPB zero_in=0 -> BRANCH=1 with ALUC=011.
  - All three return to FETCH with no WRITEREG.
- TIMEOUT=3, mem_ready held 0 in FETCH -> ERR pulse on the cycle after the 4th FETCH cycle, no IRWRITE, STATE stays FETCH.
  - Repeat with mem_ready=1 on the 4th cycle -> IRWRITE=1 and no ERR.
- Assert rst during MEM of SW -> WRITEMEM=0 in that cycle; after release STATE=FETCH, ZF_Q=CF_Q=0.
- ADDC with carry_in=1 sets CF_Q=1. A following ORI (ALUC=110, ALUSRCB=1, WRFLAG=0) -> CF_Q stays 1.
